// File: rtl/systolic_operand_feeder_if.sv
// Bundle between the operand feeder, its upstream row source and the
// attached systolic_array.
//
// Write channel : wr_valid / wr_ready handshake carrying one row of A and
//                 one row of B per transfer (element [j] is column j).
// Array channel : valid_in plus one column of A and one row of B per cycle,
//                 and arr_valid_out coming back from the array.
// Status        : busy, done (completion pulse), err (timeout pulse).
//
// master : the environment (row source and array side).
// slave  : the feeder itself.
interface systolic_operand_feeder_if #(
    parameter int N_SIZE = 3,
    parameter int DATA_W = 16
);
    logic                           wr_valid;
    logic                           wr_ready;
    logic [N_SIZE-1:0][DATA_W-1:0]  wr_a_row;
    logic [N_SIZE-1:0][DATA_W-1:0]  wr_b_row;

    logic                           valid_in;
    logic [N_SIZE-1:0][DATA_W-1:0]  matrix_a_in;
    logic [N_SIZE-1:0][DATA_W-1:0]  matrix_b_in;
    logic                           arr_valid_out;

    logic                           busy;
    logic                           done;
    logic                           err;

    modport master (
        output wr_valid, wr_a_row, wr_b_row, arr_valid_out,
        input  wr_ready, valid_in, matrix_a_in, matrix_b_in, busy, done, err
    );

    modport slave (
        input  wr_valid, wr_a_row, wr_b_row, arr_valid_out,
        output wr_ready, valid_in, matrix_a_in, matrix_b_in, busy, done, err
    );
endinterface

// File: rtl/systolic_operand_feeder.sv
// Transmit-side front end for the systolic_array matrix multiplier.
//
// Collects N_SIZE row pairs of A and B (row-major, one pair per handshake),
// then streams them to the array for N_SIZE back-to-back cycles: in cycle k
// matrix_a_in carries column k of A and matrix_b_in carries row k of B.
// Afterwards it counts valid_out rows from the array and pulses done once
// all N_SIZE rows were seen, or err if TIMEOUT_CYC cycles pass first.
//
// Ports:
//   clk    : rising-edge clock.
//   rst_n  : asynchronous active-low reset; aborts any operation.
//   bus    : slave side of systolic_operand_feeder_if (write channel,
//            array channel, busy/done/err status).
module systolic_operand_feeder #(
    parameter int N_SIZE      = 3,
    parameter int DATA_W      = 16,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    systolic_operand_feeder_if.slave  bus
);

    localparam int IDX_W = (N_SIZE > 1) ? $clog2(N_SIZE) : 1;
    localparam int CNT_W = $clog2(N_SIZE + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SIZE - 1);
    localparam logic [CNT_W-1:0] LAST_RES = CNT_W'(N_SIZE - 1);
    localparam logic [TMO_W-1:0] LAST_TMO = TMO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        LOAD     = 2'd0,
        STREAM   = 2'd1,
        WAIT_RES = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;

    logic [IDX_W-1:0]    row_cnt;
    logic [IDX_W-1:0]    stream_cnt;
    logic [CNT_W-1:0]    res_cnt;
    logic [TMO_W-1:0]    tmo_cnt;

    logic                accept;
    logic                res_hit;
    logic                tmo_hit;
    logic                done_next;
    logic                err_next;
    logic                done_q;
    logic                err_q;

    // Row-indexed operand store: a_buf[r][j] = A[r][j], b_buf[r][j] = B[r][j].
    logic [N_SIZE-1:0][DATA_W-1:0] a_buf [N_SIZE];
    logic [N_SIZE-1:0][DATA_W-1:0] b_buf [N_SIZE];

    // The final result row counts before the timeout, so a coincident
    // completion reports done rather than err.
    assign res_hit = bus.arr_valid_out && (res_cnt == LAST_RES);
    assign tmo_hit = (tmo_cnt == LAST_TMO);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a value held, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        done_next  = 1'b0;
        err_next   = 1'b0;
        unique case (state)
            LOAD: begin
                accept = bus.wr_valid;
                if (accept && (row_cnt == LAST_IDX)) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                if (stream_cnt == LAST_IDX) begin
                    state_next = WAIT_RES;
                end
            end
            WAIT_RES: begin
                if (res_hit) begin
                    done_next  = 1'b1;
                    state_next = LOAD;
                end else if (tmo_hit) begin
                    err_next   = 1'b1;
                    state_next = LOAD;
                end
            end
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_cnt    <= '0;
            stream_cnt <= '0;
            res_cnt    <= '0;
            tmo_cnt    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= done_next;
            err_q  <= err_next;
            unique case (state)
                LOAD: begin
                    if (accept) begin
                        row_cnt <= (row_cnt == LAST_IDX) ? '0 : row_cnt + IDX_W'(1);
                    end
                end
                STREAM: begin
                    stream_cnt <= (stream_cnt == LAST_IDX) ? '0 : stream_cnt + IDX_W'(1);
                    // Both result-phase counters start from zero on entry.
                    res_cnt    <= '0;
                    tmo_cnt    <= '0;
                end
                WAIT_RES: begin
                    if (state_next == LOAD) begin
                        res_cnt <= '0;
                        tmo_cnt <= '0;
                    end else begin
                        res_cnt <= res_cnt + CNT_W'(bus.arr_valid_out);
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the operand store has no reset; every entry is rewritten by a
    // full load before it is ever streamed, so clearing it buys nothing.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_buf[row_cnt] <= bus.wr_a_row;
            b_buf[row_cnt] <= bus.wr_b_row;
        end
    end

    // Column k of A is gathered across the stored rows; row k of B is a
    // stored row as-is.
    for (genvar i = 0; i < N_SIZE; i++) begin : g_col
        assign bus.matrix_a_in[i] = (state == STREAM) ? a_buf[i][stream_cnt] : '0;
    end
    assign bus.matrix_b_in = (state == STREAM) ? b_buf[stream_cnt] : '0;
    assign bus.valid_in    = (state == STREAM);

    assign bus.wr_ready = (state == LOAD);
    assign bus.busy     = (state != LOAD);
    assign bus.done     = done_q;
    assign bus.err      = err_q;

endmodule

// File: doc/systolic_operand_feeder.md
Name: systolic_operand_feeder

Overview:
Transmit-side front end for the systolic_array matrix multiplier. It accepts matrices A and B one row pair per handshake in natural row-major order and buffers the full pair. It then drives the array's operand interface for N consecutive cycles: A column-wise and B row-wise, with valid_in asserted. It tracks the array's valid_out rows to report completion, and flags a timeout if completion never arrives.

Parameters:
N_SIZE, 3, matrix dimension; must match the attached systolic_array.
DATA_W, 16, operand element width.
TIMEOUT_CYC, 64, maximum cycles in WAIT_RES before err is raised; must be greater than N_SIZE.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
wr_valid  in  1  upstream row pair valid.
wr_ready  out  1  feeder can accept a row pair.
wr_a_row  in  N_SIZE x DATA_W  row r of A; element [j] is A[r][j].
wr_b_row  in  N_SIZE x DATA_W  row r of B; element [j] is B[r][j].
valid_in  out  1  to array valid_in.
matrix_a_in  out  N_SIZE x DATA_W  to array; column k of A.
matrix_b_in  out  N_SIZE x DATA_W  to array; row k of B.
arr_valid_out  in  1  from array valid_out.
busy  out  1  high whenever state is not LOAD.
done  out  1  one-cycle pulse when all N result rows have been observed.
err  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset (async, rst_n=0):
  - State = LOAD; row, stream and result counters cleared; timeout counter cleared.
  - valid_in=0, matrix_a_in/matrix_b_in all zero, done=0, err=0, busy=0, wr_ready=1.
  - A/B buffers are not cleared.
  - Reset asserted mid-operation aborts immediately. The next cycle after release is LOAD with row count 0.
- wr_ready = (state==LOAD). busy = (state!=LOAD).
- LOAD:
  - On each edge with wr_valid && wr_ready, store wr_a_row into A_buf[row_cnt] and wr_b_row into B_buf[row_cnt], then row_cnt++.
  - wr_valid low cycles are gaps; nothing is stored.
  - On acceptance of row N_SIZE-1: row_cnt<=0, state<=STREAM.
  - arr_valid_out is ignored.
- STREAM:
  - Lasts exactly N_SIZE cycles, k = 0..N_SIZE-1.
  - The first STREAM cycle is the cycle immediately after the edge that accepted the last row.
  - In cycle k: valid_in=1, matrix_a_in[i]=A_buf[i][k] (column k of A), matrix_b_in[j]=B_buf[k][j].
  - valid_in stays high with no bubbles for all N_SIZE cycles.
  - After cycle N_SIZE-1: state<=WAIT_RES and the timeout counter is cleared.
  - wr_valid is ignored (wr_ready=0).
  - arr_valid_out is ignored.
- WAIT_RES:
  - valid_in=0 and operand outputs are zero.
  - Each cycle with arr_valid_out=1 increments res_cnt. Rows need not be consecutive.
  - When res_cnt reaches N_SIZE: done=1 for the next single cycle, state<=LOAD, res_cnt<=0.
  - The timeout counter increments every WAIT_RES cycle. On reaching TIMEOUT_CYC without completion: err=1 for one cycle, state<=LOAD, counters cleared. done is not raised.
  - If the final result row and the timeout coincide on the same edge, completion wins: done pulses and err does not.
- Outside STREAM, valid_in=0 and operand outputs are driven to zero.
- done and err are registered. They pulse in the first LOAD cycle, concurrently with wr_ready=1.
- A new matrix load may begin in that same cycle.

Test Plan:
- N=3, load A={{1,2,3},{4,5,6},{7,8,9}}, B=diag(1,2,3) back-to-back -> STREAM cycle0 a={1,4,7} b={1,0,0}; cycle1 a={2,5,8} b={0,2,0}; cycle2 a={3,6,9} b={0,0,3}; exactly 3 valid_in cycles, starting the cycle after the third accept.
- Same load with wr_valid gaps (valid 1,0,1,0,0,1) -> identical stream; wr_valid high during STREAM/WAIT_RES is not accepted (wr_ready=0); busy high from the first STREAM cycle.
- Real systolic_array N=3 attached -> done pulses once, the cycle after the 3rd arr_valid_out; array output equals {{1,4,9},{4,10,18},{7,16,27}}.
- arr_valid_out held low after STREAM, TIMEOUT_CYC=64 -> err pulses exactly 64 cycles after entering WAIT_RES, done never rises, wr_ready returns to 1.
- rst_n pulsed low during STREAM cycle 1 -> valid_in drops to 0 asynchronously; after release a fresh full 3-row load is needed before any valid_in.
- N_SIZE=5, A rows {1..5},{6..10},{11..15},{1..5},{6..10} -> STREAM cycle0 a={1,6,11,1,6}, cycle4 a={5,10,15,5,10}; b cycle k = B row k.
